instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Instruction source for `mipscpu`: buffers a program of 32-bit instruction words loaded by the testbench or host, then replays them to the CPU over the `instrword`/`newinstr` interface. Each word is presented with a one-cycle `newinstr` pulse and held stable for a programmable number of cycles, so the CPU's id/ex/mem/wb sequence completes before the next word. It sits directly upstream of `mipscpu` and shares its clock.

## Interface
- `DEPTH`, default 16: program buffer depth in words. Power of two, ≥2.
- `CYCLES_PER_INSTR`, default 4: cycles between successive `newinstr` pulses. Must be ≥1.
- `AW`, default `$clog2(DEPTH)`: buffer address width.

- `clock`, input, 1: the single clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset (active when 0).
- `load_valid`, input, 1: `load_word` is valid this cycle.
- `load_word`, input, 32: instruction word to append to the buffer.
- `load_ready`, output, 1: combinational; equals (state==IDLE && count<DEPTH).
- `clear`, input, 1: empties the buffer (count←0). Honoured only in IDLE.
- `start`, input, 1: begins replay from word 0. Honoured only in IDLE.
- `stop`, input, 1: aborts replay.
- `instrword`, output, 32: registered; the instruction presented to the CPU.
- `newinstr`, output, 1: registered; one-cycle strobe marking a new `instrword`.
- `busy`, output, 1: registered; replay in progress.
- `done`, output, 1: registered; one-cycle pulse when replay completes.
- `count`, output, AW+1: number of words loaded (0..DEPTH).
- `pc`, output, AW: index of the word currently presented.

## Operation
- States: IDLE, ISSUE, HOLD.
- **IDLE**
  - If `load_valid && load_ready`: write `load_word` to buf[count], then count++.
  - If `load_valid` is asserted when full: the word is dropped and count is unchanged.
  - `clear` takes priority over a same-cycle load.
  - `start` with count>0: pc←0, go to ISSUE. `start` in the same cycle as `clear` or a load is evaluated against the pre-edge count; the load/clear still takes effect.
  - `start` with count==0: `done` pulses the next cycle and the block stays in IDLE.
- **ISSUE** (exactly 1 cycle)
  - On entry: `instrword`←buf[pc], `newinstr`=1, `busy`=1, timer←CYCLES_PER_INSTR−1.
  - Then go to HOLD, or directly to the next ISSUE/end decision if CYCLES_PER_INSTR==1.
- **HOLD**
  - `newinstr`=0 and `instrword` is held.
  - The timer decrements each cycle. When it reaches 0:
    - If pc==count−1: go to IDLE, `busy`←0, `done`←1 for one cycle.
    - Otherwise: pc++, go to ISSUE.
- `stop` in ISSUE or HOLD: go to IDLE the next cycle. `busy`←0, no `done`, `instrword` is held, and buffer and count are retained.
- `start`, `clear` and loads are ignored while busy. `stop` is ignored in IDLE.
- The buffer and count persist after completion, so a second `start` replays the same program.
- Buffer contents are not reset. Only count and pc are reset.

## Timing
- Reset values: `instrword`=0, `newinstr`=0, `busy`=0, `done`=0, `count`=0, `pc`=0, state=IDLE. `load_ready`=1 while in reset.
- If `start` is sampled at edge E0:
  - word k appears with `newinstr`=1 in cycle 1+k·C, where C=CYCLES_PER_INSTR.
  - `busy` is high from cycle 1 through N·C.
  - `done` is high in cycle 1+N·C, with `busy`=0. N = count.
- With C==1, `newinstr` stays high for N consecutive cycles with a new word each cycle.
- A load becomes visible in `count` one cycle after the accepting edge.
- Reset asserted mid-replay takes effect immediately, with no `done` pulse. The program must be reloaded.

## Structure
- Package `mips_pkg`:
  - `INSTR_W`=32.
  - `seq_state_t` enum {IDLE, ISSUE, HOLD}.
  - `DEFAULT_CYCLES_PER_INSTR`=4.
- Sub-module `instr_buffer`: DEPTH×32 register array with one synchronous write port and one asynchronous read port, no reset.
- `instr_sequencer` contains the FSM, timer, count and pc.

## Test plan
- Reset → load 0x20080005, 0x20090003, 0x01095020 → `start`: `newinstr` pulses at cycles 1, 5, 9 carrying those words in order. `done` at cycle 13, `busy` high for cycles 1–12.
- Load 16 words with `load_valid` held for 17 cycles: `load_ready` drops after the 16th, count=16, the 17th word is dropped, and replay emits exactly 16 words.
- `start` with an empty buffer: `done` pulses one cycle later, no `newinstr`, `busy` stays 0.
- `stop` during HOLD of word 1 of 3: IDLE next cycle, `instrword` retains word 1, no `done`. A subsequent `start` replays from word 0.
- `clear` plus `load_valid` in the same IDLE cycle: count=0. `clear` or `start` during busy: ignored.
- Drive `reset`=0 at cycle 6 of a replay: all outputs return to reset values asynchronously and count=0. With C=1, replaying 2 words gives `newinstr` high in cycles 1–2 and `done` in cycle 3.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the mipscpu instruction source.
package mips_pkg;

    localparam int INSTR_W                  = 32;
    localparam int DEFAULT_CYCLES_PER_INSTR = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } seq_state_t;

endpackage

// File: rtl/instr_buffer.sv
// Program store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; a fresh program is loaded after reset.
module instr_buffer
    import mips_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// Buffers a program of instruction words and replays them to mipscpu,
// one newinstr strobe every CYCLES_PER_INSTR cycles.
//
// state | meaning
// IDLE  | loading / clearing allowed, waiting for start
// ISSUE | cycle in which a new instrword is presented (newinstr high)
// HOLD  | instrword held while the CPU works through it
module instr_sequencer
    import mips_pkg::*;
#(
    parameter int DEPTH            = 16,
    parameter int CYCLES_PER_INSTR = DEFAULT_CYCLES_PER_INSTR,
    parameter int AW               = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_word,
    output logic               load_ready,
    input  logic               clear,
    input  logic               start,
    input  logic               stop,
    output logic [INSTR_W-1:0] instrword,
    output logic               newinstr,
    output logic               busy,
    output logic               done,
    output logic [AW:0]        count,
    output logic [AW-1:0]      pc
);

    localparam int TW = (CYCLES_PER_INSTR > 1) ? $clog2(CYCLES_PER_INSTR) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(CYCLES_PER_INSTR - 1);

    seq_state_t         state, state_nx;
    logic [TW-1:0]      timer, timer_nx;
    logic [AW:0]        count_nx;
    logic [AW-1:0]      pc_nx;
    logic [INSTR_W-1:0] instrword_nx;
    logic               newinstr_nx, busy_nx, done_nx;
    logic               wr_en;
    logic [AW-1:0]      rd_addr;
    logic [INSTR_W-1:0] rd_data;
    logic               last_word;

    instr_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buffer (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (count[AW-1:0]),
        .wr_data (load_word),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign load_ready = (state == IDLE) && (count < (AW+1)'(DEPTH));
    assign last_word  = ({1'b0, pc} == (count - (AW+1)'(1)));
    // In IDLE the only word ever fetched is word 0; while replaying it is the next one.
    assign rd_addr    = (state == IDLE) ? '0 : (pc + AW'(1));

    always_comb begin
        state_nx     = state;
        timer_nx     = timer;
        count_nx     = count;
        pc_nx        = pc;
        instrword_nx = instrword;
        newinstr_nx  = 1'b0;
        busy_nx      = busy;
        done_nx      = 1'b0;
        wr_en        = 1'b0;
        case (state)
            IDLE: begin
                if (clear) begin
                    count_nx = '0;
                end else if (load_valid && load_ready) begin
                    wr_en    = 1'b1;
                    count_nx = count + (AW+1)'(1);
                end
                if (start) begin
                    if (count != '0) begin
                        state_nx     = ISSUE;
                        pc_nx        = '0;
                        instrword_nx = rd_data;
                        newinstr_nx  = 1'b1;
                        busy_nx      = 1'b1;
                        timer_nx     = TIMER_LOAD;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            ISSUE, HOLD: begin
                if (stop) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end else if (timer != '0) begin
                    timer_nx = timer - TW'(1);
                    state_nx = HOLD;
                end else if (last_word) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end else begin
                    state_nx     = ISSUE;
                    pc_nx        = pc + AW'(1);
                    instrword_nx = rd_data;
                    newinstr_nx  = 1'b1;
                    timer_nx     = TIMER_LOAD;
                end
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            timer     <= '0;
            count     <= '0;
            pc        <= '0;
            instrword <= '0;
            newinstr  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            count     <= count_nx;
            pc        <= pc_nx;
            instrword <= instrword_nx;
            newinstr  <= newinstr_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench: default-parameter sequencer plus a single-cycle-per-word instance.
module tb_instr_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_word = '0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;

    logic        load_ready, newinstr, busy, done;
    logic [31:0] instrword;
    logic [4:0]  count;
    logic [3:0]  pc;

    logic        c1_load_ready, c1_newinstr, c1_busy, c1_done;
    logic [31:0] c1_instrword;
    logic [4:0]  c1_count;
    logic [3:0]  c1_pc;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_w [17];

    instr_sequencer #(.DEPTH(16), .CYCLES_PER_INSTR(4)) dut (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_word(load_word),
        .load_ready(load_ready), .clear(clear), .start(start), .stop(stop),
        .instrword(instrword), .newinstr(newinstr), .busy(busy), .done(done),
        .count(count), .pc(pc)
    );

    instr_sequencer #(.DEPTH(16), .CYCLES_PER_INSTR(1)) dut_c1 (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_word(load_word),
        .load_ready(c1_load_ready), .clear(clear), .start(start), .stop(stop),
        .instrword(c1_instrword), .newinstr(c1_newinstr), .busy(c1_busy), .done(c1_done),
        .count(c1_count), .pc(c1_pc)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic load_n(input int n);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_word  = exp_w[i];
            tick();
        end
        load_valid = 1'b0;
    endtask

    // Replay on the C=4 instance from a start pulse through the done pulse.
    task automatic run_replay(input int n, input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= n * 4; cyc++) begin
            chk({tag, "_newinstr"}, {31'b0, newinstr}, {31'b0, ((cyc - 1) % 4) == 0});
            chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
            chk({tag, "_done_early"}, {31'b0, done}, 32'd0);
            if (((cyc - 1) % 4) == 0) begin
                chk({tag, "_word"}, instrword, exp_w[(cyc - 1) / 4]);
            end
            tick();
        end
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
        chk({tag, "_newinstr_end"}, {31'b0, newinstr}, 32'd0);
        tick();
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        bit seen;

        #2;
        chk("rst_instrword", instrword, 32'h0);
        chk("rst_newinstr", {31'b0, newinstr}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_count", {27'b0, count}, 32'd0);
        chk("rst_pc", {28'b0, pc}, 32'd0);
        chk("rst_load_ready", {31'b0, load_ready}, 32'd1);
        tick();
        reset = 1'b1;
        tick();

        exp_w[0] = 32'h2008_0005;
        exp_w[1] = 32'h2009_0003;
        exp_w[2] = 32'h0109_5020;
        load_valid = 1'b1;
        load_word  = exp_w[0];
        tick();
        chk("load_count1", {27'b0, count}, 32'd1);
        load_word = exp_w[1];
        tick();
        load_word = exp_w[2];
        tick();
        load_valid = 1'b0;
        chk("load_count3", {27'b0, count}, 32'd3);
        run_replay(3, "prog3");

        // stop during HOLD of word 1
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("stop_pre_busy", {31'b0, busy}, 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", {31'b0, busy}, 32'd0);
        chk("stop_newinstr", {31'b0, newinstr}, 32'd0);
        chk("stop_word", instrword, exp_w[1]);
        chk("stop_done", {31'b0, done}, 32'd0);
        tick();
        chk("stop_done_later", {31'b0, done}, 32'd0);
        chk("stop_count", {27'b0, count}, 32'd3);
        run_replay(3, "restart");

        // clear wins over a same-cycle load
        clear = 1'b1;
        load_valid = 1'b1;
        load_word = 32'hFFFF_0000;
        tick();
        clear = 1'b0;
        load_valid = 1'b0;
        chk("clear_load_count", {27'b0, count}, 32'd0);
        load_n(2);
        chk("reload_count", {27'b0, count}, 32'd2);

        // clear/start/load while busy are ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        clear = 1'b1;
        start = 1'b1;
        load_valid = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        load_valid = 1'b0;
        chk("busy_ignore_count", {27'b0, count}, 32'd2);
        chk("busy_ignore_busy", {31'b0, busy}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        chk("busy_ignore_done_seen", {31'b0, seen}, 32'd1);
        tick();

        // start with an empty buffer
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("empty_count", {27'b0, count}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_done", {31'b0, done}, 32'd1);
        chk("empty_busy", {31'b0, busy}, 32'd0);
        chk("empty_newinstr", {31'b0, newinstr}, 32'd0);
        tick();
        chk("empty_done_pulse", {31'b0, done}, 32'd0);
        chk("empty_busy2", {31'b0, busy}, 32'd0);

        // fill to DEPTH with one extra word offered
        for (int i = 0; i < 16; i++) exp_w[i] = 32'hA000_0000 + 32'(i * 3);
        exp_w[16] = 32'hDEAD_BEEF;
        for (int i = 0; i < 17; i++) begin
            load_valid = 1'b1;
            load_word  = exp_w[i];
            chk("full_load_ready", {31'b0, load_ready}, {31'b0, i < 16});
            tick();
        end
        load_valid = 1'b0;
        chk("full_count", {27'b0, count}, 32'd16);
        chk("full_load_ready_after", {31'b0, load_ready}, 32'd0);
        run_replay(16, "full16");

        // asynchronous reset mid-replay
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("arst_pre_busy", {31'b0, busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_newinstr", {31'b0, newinstr}, 32'd0);
        chk("arst_instrword", instrword, 32'h0);
        chk("arst_count", {27'b0, count}, 32'd0);
        chk("arst_pc", {28'b0, pc}, 32'd0);
        chk("arst_load_ready", {31'b0, load_ready}, 32'd1);
        tick();
        chk("arst_done", {31'b0, done}, 32'd0);
        reset = 1'b1;
        tick();

        // single cycle per word
        exp_w[0] = 32'h1111_2222;
        exp_w[1] = 32'h3333_4444;
        load_n(2);
        chk("c1_count", {27'b0, c1_count}, 32'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("c1_cyc1_newinstr", {31'b0, c1_newinstr}, 32'd1);
        chk("c1_cyc1_word", c1_instrword, exp_w[0]);
        chk("c1_cyc1_busy", {31'b0, c1_busy}, 32'd1);
        tick();
        chk("c1_cyc2_newinstr", {31'b0, c1_newinstr}, 32'd1);
        chk("c1_cyc2_word", c1_instrword, exp_w[1]);
        chk("c1_cyc2_done", {31'b0, c1_done}, 32'd0);
        tick();
        chk("c1_cyc3_done", {31'b0, c1_done}, 32'd1);
        chk("c1_cyc3_busy", {31'b0, c1_busy}, 32'd0);
        chk("c1_cyc3_newinstr", {31'b0, c1_newinstr}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
